load_store_unit: RTL and testbench
==================================

# load_store_unit

Parametrised load/store unit between the MEM stage and the data-memory port. It accepts one load or store per request, drives a req/gnt/rvalid bus with byte enables, and places store data on the correct byte lanes. It extracts and sign- or zero-extends load data, detects misaligned or illegal accesses without touching the bus, and stalls the pipeline while a transaction is outstanding.

## Interface
Parameters:
- DATA_WIDTH, default 32: bus and register data width. Legal values are 32 and 64.
- ADDR_WIDTH, default 32: byte-address width.
- Derived: BE_WIDTH = DATA_WIDTH/8 and OFF_W = log2(BE_WIDTH).

Ports:
- clk_i  in  1  clock; one clock, all logic on its rising edge
- rst_i  in  1  reset; reset is asynchronous and active-high
- data_req_o  out  1  bus request
- data_gnt_i  in  1  bus grant
- data_rvalid_i  in  1  response valid
- data_addr_o  out  ADDR_WIDTH  address, aligned to BE_WIDTH
- data_we_o  out  1  write enable
- data_be_o  out  BE_WIDTH  byte enables
- data_wdata_o  out  DATA_WIDTH  lane-aligned write data
- data_rdata_i  in  DATA_WIDTH  read data
- mem_req_i  in  1  access request from the MEM stage
- mem_we_i  in  1  1 = store, 0 = load
- mem_data_type_i  in  2  access size: 00 = byte, 01 = half, 10 = word, 11 = dword (dword legal only when DATA_WIDTH = 64)
- mem_sign_ext_i  in  1  sign-extend load data
- mem_wdata_i  in  DATA_WIDTH  store data, right-aligned
- mem_addr_i  in  ADDR_WIDTH  byte address
- mem_rdata_o  out  DATA_WIDTH  extended load data
- mem_rvalid_o  out  1  one-cycle completion pulse
- mem_err_o  out  1  one-cycle misaligned/illegal pulse
- mem_busy_o  out  1  unit not idle; MEM stage must stall

## Operation
- State machine: IDLE, WAIT_GNT, WAIT_RVALID.
- IDLE, mem_req_i = 1, access legal:
  - Latch the aligned address, we, be, shifted wdata, size, sign flag and offset = addr[OFF_W-1:0].
  - Go to WAIT_GNT.
- IDLE, mem_req_i = 1, access illegal:
  - Pulse mem_err_o on the next cycle, stay in IDLE, issue no bus request.
  - Illegal cases: half with addr[0] ≠ 0; word with addr[1:0] ≠ 0; dword with addr[2:0] ≠ 0; dword when DATA_WIDTH = 32.
- WAIT_GNT: data_req_o = 1 and all bus outputs held stable. On data_gnt_i, go to WAIT_RVALID. data_rvalid_i is ignored in this state.
- WAIT_RVALID: data_req_o = 0. On data_rvalid_i, go to IDLE.
  - Load: register the extracted data into mem_rdata_o.
  - Store: leave mem_rdata_o unchanged.
  - In both cases pulse mem_rvalid_o on the next cycle.
- Byte enables, shifted left by offset:
  - byte = 1
  - half = 3
  - word = 0xF
  - dword = all ones
- Write data: mem_wdata_i shifted left by 8·offset; bits shifted out are dropped.
- Load data:
  - Source: data_rdata_i shifted right by 8·offset, truncated to the access size.
  - Extension: sign-extended from the top bit of the field if mem_sign_ext_i was latched as 1, zero-extended otherwise.
  - A full-width access bypasses extension.
- mem_busy_o = (state ≠ IDLE), combinational.
- Requests are accepted only in IDLE. mem_req_i in any other state is ignored; the stall keeps it asserted.
- Only one transaction may be outstanding at a time.

## Timing
- Reset values:
  - state = IDLE
  - data_req_o = 0, data_we_o = 0, data_be_o = 0
  - data_addr_o = 0, data_wdata_o = 0
  - mem_rdata_o = 0, mem_rvalid_o = 0, mem_err_o = 0, mem_busy_o = 0
- Latency, request accepted at cycle 0:
  - data_req_o is high from cycle 1.
  - With grant at cycle g and rvalid at cycle r > g, mem_rvalid_o is high at cycle r+1.
  - Minimum load-to-use is 3 cycles (g = 1, r = 2).
- Bus rules:
  - Bus outputs are registered and change only on acceptance in IDLE.
  - data_rvalid_i in the same cycle as data_gnt_i is not a legal bus response and is ignored.
- Back-to-back: a new request is accepted on the cycle mem_busy_o returns to 0, i.e. the cycle mem_rvalid_o is high.
- mem_err_o and mem_rvalid_o are never asserted together.
- Reset mid-transaction:
  - The unit returns to IDLE and all outputs go to their reset values.
  - The outstanding bus transaction is abandoned.
  - A later data_rvalid_i arriving in IDLE is ignored and produces no mem_rvalid_o.

## Test plan
- Word load, DATA_WIDTH = 32, addr 0x100, gnt at cycle 1, rvalid = 0xDEADBEEF at cycle 2 -> data_addr_o = 0x100, be = 0xF, mem_rvalid_o at cycle 3, mem_rdata_o = 0xDEADBEEF.
- Signed byte load at addr 0x103, rdata 0x80FF_1234 -> be = 0x8, mem_rdata_o = 0xFFFF_FF80. The unsigned variant gives 0x0000_0080.
- Half store at addr 0x102, wdata 0x0000_ABCD, grant delayed 3 cycles:
  - Bus outputs: be = 0xC, data_wdata_o = 0xABCD_0000, data_req_o held 4 cycles with stable outputs.
  - Completion: mem_rvalid_o pulses, mem_rdata_o unchanged.
- Misaligned word load at addr 0x101 -> mem_err_o pulses once, data_req_o stays 0, mem_busy_o stays 0. Dword with DATA_WIDTH = 32 also gives mem_err_o.
- DATA_WIDTH = 64, dword load at 0x08, rdata 0x0123456789ABCDEF -> be = 0xFF, mem_rdata_o equals the rdata. A signed word load at 0x0C returns 0x0000_0000_0123_4567.
- Assert rst_i in WAIT_RVALID, then drive rvalid after reset -> all outputs 0, no mem_rvalid_o; the next request then completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: MEM-stage requests to a req/gnt/rvalid data bus.
// Ports: clk_i, rst_i, data_* (bus side), mem_* (pipeline side).
module load_store_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   output logic                    data_req_o,
   input  logic                    data_gnt_i,
   input  logic                    data_rvalid_i,
   output logic [ADDR_WIDTH-1:0]   data_addr_o,
   output logic                    data_we_o,
   output logic [DATA_WIDTH/8-1:0] data_be_o,
   output logic [DATA_WIDTH-1:0]   data_wdata_o,
   input  logic [DATA_WIDTH-1:0]   data_rdata_i,
   input  logic                    mem_req_i,
   input  logic                    mem_we_i,
   input  logic [1:0]              mem_data_type_i,
   input  logic                    mem_sign_ext_i,
   input  logic [DATA_WIDTH-1:0]   mem_wdata_i,
   input  logic [ADDR_WIDTH-1:0]   mem_addr_i,
   output logic [DATA_WIDTH-1:0]   mem_rdata_o,
   output logic                    mem_rvalid_o,
   output logic                    mem_err_o,
   output logic                    mem_busy_o
);

   localparam int BE_WIDTH = DATA_WIDTH / 8;
   localparam int OFF_W    = $clog2(BE_WIDTH);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_GNT,
      WAIT_RVALID
   } state_t;

   state_t state;

   logic [1:0]            size_q;
   logic                  sign_q;
   logic [OFF_W-1:0]      off_q;

   logic                  legal;
   logic [BE_WIDTH-1:0]   be_base;
   logic [OFF_W-1:0]      off_in;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] mask;
   logic                  sbit;
   logic [DATA_WIDTH-1:0] rdata_ext;

   assign off_in = mem_addr_i[OFF_W-1:0];

   always_comb begin
      legal   = 1'b1;
      be_base = '0;
      case (mem_data_type_i)
         2'b00: be_base = BE_WIDTH'(1'b1);
         2'b01: begin
            be_base = BE_WIDTH'(2'b11);
            legal   = ~mem_addr_i[0];
         end
         2'b10: begin
            be_base = BE_WIDTH'(4'hF);
            legal   = (mem_addr_i[1:0] == 2'b00);
         end
         default: begin
            be_base = '1;
            legal   = (DATA_WIDTH == 64) &&
                      (mem_addr_i[2:0] == 3'b000);
         end
      endcase
   end

   // Field mask doubles as the extension boundary; a full-width
   // access yields an all-ones mask so no extension is applied.
   assign shifted = data_rdata_i >> {off_q, 3'b000};

   always_comb begin
      mask = '1;
      sbit = shifted[DATA_WIDTH-1];
      case (size_q)
         2'b00: begin
            mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 8);
            sbit = shifted[7];
         end
         2'b01: begin
            mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 16);
            sbit = shifted[15];
         end
         2'b10: begin
            mask = {DATA_WIDTH{1'b1}} >> (DATA_WIDTH - 32);
            sbit = shifted[31];
         end
         default: begin
            mask = '1;
            sbit = shifted[DATA_WIDTH-1];
         end
      endcase
   end

   assign rdata_ext = (shifted & mask) |
                      ((sign_q & sbit) ? ~mask : '0);

   assign mem_busy_o = (state != IDLE);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= IDLE;
         size_q       <= '0;
         sign_q       <= 1'b0;
         off_q        <= '0;
         data_req_o   <= 1'b0;
         data_we_o    <= 1'b0;
         data_be_o    <= '0;
         data_addr_o  <= '0;
         data_wdata_o <= '0;
         mem_rdata_o  <= '0;
         mem_rvalid_o <= 1'b0;
         mem_err_o    <= 1'b0;
      end else begin
         mem_rvalid_o <= 1'b0;
         mem_err_o    <= 1'b0;
         case (state)
            IDLE: begin
               if (mem_req_i) begin
                  if (legal) begin
                     data_addr_o  <= {mem_addr_i[ADDR_WIDTH-1:OFF_W],
                                      {OFF_W{1'b0}}};
                     data_we_o    <= mem_we_i;
                     data_be_o    <= be_base << off_in;
                     data_wdata_o <= mem_wdata_i << {off_in, 3'b000};
                     size_q       <= mem_data_type_i;
                     sign_q       <= mem_sign_ext_i;
                     off_q        <= off_in;
                     data_req_o   <= 1'b1;
                     state        <= WAIT_GNT;
                  end else begin
                     mem_err_o <= 1'b1;
                  end
               end
            end
            WAIT_GNT: begin
               if (data_gnt_i) begin
                  data_req_o <= 1'b0;
                  state      <= WAIT_RVALID;
               end
            end
            WAIT_RVALID: begin
               if (data_rvalid_i) begin
                  if (!data_we_o)
                     mem_rdata_o <= rdata_ext;
                  mem_rvalid_o <= 1'b1;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit at DATA_WIDTH 32 and 64.
// Cycle n is the interval starting 1 time unit after the nth edge.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;

   // 32-bit instance
   logic        req, gnt, rvalid, we, mreq, mwe, sext;
   logic        mrvalid, merr, busy;
   logic [1:0]  dtype;
   logic [31:0] addr, wdata, rdata, mwdata, maddr, mrdata;
   logic [3:0]  be;

   // 64-bit instance
   logic        req6, gnt6, rvalid6, we6, mreq6, mwe6, sext6;
   logic        mrvalid6, merr6, busy6;
   logic [1:0]  dtype6;
   logic [31:0] addr6, maddr6;
   logic [63:0] wdata6, rdata6, mwdata6, mrdata6;
   logic [7:0]  be6;

   load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
      .clk_i(clk), .rst_i(rst),
      .data_req_o(req), .data_gnt_i(gnt), .data_rvalid_i(rvalid),
      .data_addr_o(addr), .data_we_o(we), .data_be_o(be),
      .data_wdata_o(wdata), .data_rdata_i(rdata),
      .mem_req_i(mreq), .mem_we_i(mwe), .mem_data_type_i(dtype),
      .mem_sign_ext_i(sext), .mem_wdata_i(mwdata), .mem_addr_i(maddr),
      .mem_rdata_o(mrdata), .mem_rvalid_o(mrvalid),
      .mem_err_o(merr), .mem_busy_o(busy)
   );

   load_store_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32)) dut64 (
      .clk_i(clk), .rst_i(rst),
      .data_req_o(req6), .data_gnt_i(gnt6), .data_rvalid_i(rvalid6),
      .data_addr_o(addr6), .data_we_o(we6), .data_be_o(be6),
      .data_wdata_o(wdata6), .data_rdata_i(rdata6),
      .mem_req_i(mreq6), .mem_we_i(mwe6), .mem_data_type_i(dtype6),
      .mem_sign_ext_i(sext6), .mem_wdata_i(mwdata6), .mem_addr_i(maddr6),
      .mem_rdata_o(mrdata6), .mem_rvalid_o(mrvalid6),
      .mem_err_o(merr6), .mem_busy_o(busy6)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic w, input logic [1:0] t,
                        input logic s, input logic [31:0] a,
                        input logic [31:0] d);
      mreq = 1'b1; mwe = w; dtype = t; sext = s; maddr = a; mwdata = d;
   endtask

   task automatic test_reset();
      n_cmp++;
      if ({req, we, be, addr, wdata, mrdata, mrvalid, merr, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset32 got req=%b we=%b be=%h addr=%h wd=%h rd=%h rv=%b err=%b busy=%b want all 0",
                  req, we, be, addr, wdata, mrdata, mrvalid, merr, busy);
      end
      n_cmp++;
      if ({req6, we6, be6, addr6, wdata6, mrdata6, mrvalid6, merr6, busy6} !== '0) begin
         n_bad++;
         $display("FAIL reset64 got req=%b be=%h addr=%h rd=%h busy=%b want all 0",
                  req6, be6, addr6, mrdata6, busy6);
      end
   endtask

   task automatic test_word_load();
      issue(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      step();
      mreq = 1'b0;
      n_cmp++;
      if (req !== 1'b1 || addr !== 32'h100 || be !== 4'hF || we !== 1'b0 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL word_load_bus got req=%b addr=%h be=%h we=%b busy=%b want 1 00000100 f 0 1",
                  req, addr, be, we, busy);
      end
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'hDEADBEEF;
      n_cmp++;
      if (req !== 1'b0 || mrvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL word_load_c2 got req=%b rv=%b want 0 0", req, mrvalid);
      end
      step();
      rvalid = 1'b0;
      n_cmp++;
      if (mrvalid !== 1'b1 || mrdata !== 32'hDEADBEEF || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL word_load_done got rv=%b rd=%h busy=%b want 1 deadbeef 0",
                  mrvalid, mrdata, busy);
      end
      step();
      n_cmp++;
      if (mrvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL word_load_pulse got rv=%b want 0", mrvalid);
      end
   endtask

   task automatic test_byte_load(input logic s, input logic [31:0] exp);
      issue(1'b0, 2'b00, s, 32'h103, 32'h0);
      step();
      mreq = 1'b0;
      n_cmp++;
      if (be !== 4'h8 || addr !== 32'h100) begin
         n_bad++;
         $display("FAIL byte_load_bus got be=%h addr=%h want 8 00000100", be, addr);
      end
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h80FF1234;
      step();
      rvalid = 1'b0;
      n_cmp++;
      if (mrvalid !== 1'b1 || mrdata !== exp) begin
         n_bad++;
         $display("FAIL byte_load_s%0b got rv=%b rd=%h want 1 %h", s, mrvalid, mrdata, exp);
      end
      step();
   endtask

   task automatic test_half_store();
      issue(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD);
      step();
      mreq = 1'b0;
      for (int c = 1; c <= 4; c++) begin
         n_cmp++;
         if (req !== 1'b1 || we !== 1'b1 || be !== 4'hC ||
             wdata !== 32'hABCD0000 || addr !== 32'h100) begin
            n_bad++;
            $display("FAIL half_store_c%0d got req=%b we=%b be=%h wd=%h addr=%h want 1 1 c abcd0000 00000100",
                     c, req, we, be, wdata, addr);
         end
         // response during grant wait must be ignored
         rvalid = (c == 2);
         gnt = (c == 4);
         step();
      end
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h12345678;
      n_cmp++;
      if (req !== 1'b0 || busy !== 1'b1 || mrvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL half_store_c5 got req=%b busy=%b rv=%b want 0 1 0", req, busy, mrvalid);
      end
      step();
      rvalid = 1'b0;
      n_cmp++;
      if (mrvalid !== 1'b1 || mrdata !== 32'h00000080) begin
         n_bad++;
         $display("FAIL half_store_done got rv=%b rd=%h want 1 00000080", mrvalid, mrdata);
      end
      step();
   endtask

   task automatic test_misaligned(input logic [1:0] t, input logic [31:0] a);
      issue(1'b0, t, 1'b0, a, 32'h0);
      step();
      mreq = 1'b0;
      n_cmp++;
      if (merr !== 1'b1 || req !== 1'b0 || busy !== 1'b0 || mrvalid !== 1'b0) begin
         n_bad++;
         $display("FAIL misalign_t%0d got err=%b req=%b busy=%b rv=%b want 1 0 0 0",
                  t, merr, req, busy, mrvalid);
      end
      step();
      n_cmp++;
      if (merr !== 1'b0 || req !== 1'b0) begin
         n_bad++;
         $display("FAIL misalign_pulse_t%0d got err=%b req=%b want 0 0", t, merr, req);
      end
   endtask

   task automatic test_back_to_back();
      issue(1'b0, 2'b01, 1'b1, 32'h202, 32'h0);
      step();
      mreq = 1'b0; gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h8001_0000;
      step();
      rvalid = 1'b0;
      n_cmp++;
      if (mrvalid !== 1'b1 || mrdata !== 32'hFFFF8001 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_first got rv=%b rd=%h busy=%b want 1 ffff8001 0", mrvalid, mrdata, busy);
      end
      issue(1'b1, 2'b00, 1'b0, 32'h201, 32'h0000005A);
      step();
      mreq = 1'b0;
      n_cmp++;
      if (req !== 1'b1 || be !== 4'h2 || wdata !== 32'h00005A00 || addr !== 32'h200) begin
         n_bad++;
         $display("FAIL b2b_second got req=%b be=%h wd=%h addr=%h want 1 2 00005a00 00000200",
                  req, be, wdata, addr);
      end
      gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1;
      step();
      rvalid = 1'b0;
      n_cmp++;
      if (mrvalid !== 1'b1 || mrdata !== 32'hFFFF8001) begin
         n_bad++;
         $display("FAIL b2b_store_done got rv=%b rd=%h want 1 ffff8001", mrvalid, mrdata);
      end
      step();
   endtask

   task automatic test_wide();
      mreq6 = 1'b1; mwe6 = 1'b0; dtype6 = 2'b11; sext6 = 1'b1; maddr6 = 32'h08;
      step();
      mreq6 = 1'b0;
      n_cmp++;
      if (req6 !== 1'b1 || be6 !== 8'hFF || addr6 !== 32'h08) begin
         n_bad++;
         $display("FAIL dword_bus got req=%b be=%h addr=%h want 1 ff 00000008", req6, be6, addr6);
      end
      gnt6 = 1'b1;
      step();
      gnt6 = 1'b0; rvalid6 = 1'b1; rdata6 = 64'h0123456789ABCDEF;
      step();
      rvalid6 = 1'b0;
      n_cmp++;
      if (mrvalid6 !== 1'b1 || mrdata6 !== 64'h0123456789ABCDEF) begin
         n_bad++;
         $display("FAIL dword_load got rv=%b rd=%h want 1 0123456789abcdef", mrvalid6, mrdata6);
      end
      mreq6 = 1'b1; dtype6 = 2'b10; sext6 = 1'b1; maddr6 = 32'h0C;
      step();
      mreq6 = 1'b0;
      n_cmp++;
      if (be6 !== 8'hF0 || addr6 !== 32'h08) begin
         n_bad++;
         $display("FAIL word64_bus got be=%h addr=%h want f0 00000008", be6, addr6);
      end
      gnt6 = 1'b1;
      step();
      gnt6 = 1'b0; rvalid6 = 1'b1;
      step();
      rvalid6 = 1'b0;
      n_cmp++;
      if (mrvalid6 !== 1'b1 || mrdata6 !== 64'h0000000001234567) begin
         n_bad++;
         $display("FAIL word64_load got rv=%b rd=%h want 1 0000000001234567", mrvalid6, mrdata6);
      end
      rdata6 = 64'hFEDCBA9876543210;
      mreq6 = 1'b1; dtype6 = 2'b01; sext6 = 1'b1; maddr6 = 32'h0E;
      step();
      mreq6 = 1'b0; gnt6 = 1'b1;
      step();
      gnt6 = 1'b0; rvalid6 = 1'b1;
      step();
      rvalid6 = 1'b0;
      n_cmp++;
      if (mrdata6 !== 64'hFFFFFFFFFFFFFEDC) begin
         n_bad++;
         $display("FAIL half64_load got rd=%h want fffffffffffffedc", mrdata6);
      end
      step();
   endtask

   task automatic test_reset_mid();
      issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
      step();
      mreq = 1'b0; gnt = 1'b1;
      step();
      gnt = 1'b0;
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({req, we, be, addr, wdata, mrdata, mrvalid, merr, busy} !== '0) begin
         n_bad++;
         $display("FAIL reset_mid got req=%b be=%h addr=%h rd=%h busy=%b want all 0",
                  req, be, addr, mrdata, busy);
      end
      step();
      rst = 1'b0;
      rvalid = 1'b1; rdata = 32'h55555555;
      step();
      rvalid = 1'b0;
      n_cmp++;
      if (mrvalid !== 1'b0 || busy !== 1'b0 || mrdata !== 32'h0) begin
         n_bad++;
         $display("FAIL stale_rvalid got rv=%b busy=%b rd=%h want 0 0 0", mrvalid, busy, mrdata);
      end
      issue(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
      step();
      mreq = 1'b0; gnt = 1'b1;
      step();
      gnt = 1'b0; rvalid = 1'b1; rdata = 32'h11223344;
      step();
      rvalid = 1'b0;
      n_cmp++;
      if (mrvalid !== 1'b1 || mrdata !== 32'h11223344) begin
         n_bad++;
         $display("FAIL after_reset got rv=%b rd=%h want 1 11223344", mrvalid, mrdata);
      end
      step();
   endtask

   initial begin
      gnt = 0; rvalid = 0; rdata = '0;
      mreq = 0; mwe = 0; dtype = '0; sext = 0; mwdata = '0; maddr = '0;
      gnt6 = 0; rvalid6 = 0; rdata6 = '0;
      mreq6 = 0; mwe6 = 0; dtype6 = '0; sext6 = 0; mwdata6 = '0; maddr6 = '0;
      step();
      test_reset();
      step();
      rst = 1'b0;
      step();
      test_word_load();
      test_byte_load(1'b1, 32'hFFFFFF80);
      test_byte_load(1'b0, 32'h00000080);
      test_half_store();
      test_misaligned(2'b10, 32'h101);
      test_misaligned(2'b11, 32'h100);
      test_misaligned(2'b01, 32'h103);
      test_back_to_back();
      test_wide();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
